// File: rtl/int_to_float.sv
// 32-bit integer to IEEE-754 single-precision converter, round to nearest even.
// Normalises one bit per cycle; stb/ack handshake on both sides, one operand in flight.
module int_to_float #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    // state        | meaning
    // st_get_a     | ready for an operand, input_a_ack high
    // st_convert_0 | zero bypass, or take sign and magnitude
    // st_convert_1 | shift magnitude left until the leading one reaches bit 31
    // st_convert_2 | split normalised magnitude into mantissa, guard, round, sticky
    // st_round     | round to nearest, ties to even
    // st_pack      | assemble sign, biased exponent and fraction
    // st_put_z     | present result until the consumer accepts it
    typedef enum logic [2:0] {
        st_get_a,
        st_convert_0,
        st_convert_1,
        st_convert_2,
        st_round,
        st_pack,
        st_put_z
    } state_t;

    state_t      state;
    logic [31:0] a;
    logic [31:0] m;
    logic [31:0] z;
    logic [23:0] z_m;
    logic [7:0]  z_e;
    logic        z_s;
    logic        guard;
    logic        round_bit;
    logic        sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= st_get_a;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            case (state)
                st_get_a: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= st_convert_0;
                    end
                end
                st_convert_0: begin
                    if (a == 32'd0) begin
                        z     <= 32'h0000_0000;
                        state <= st_put_z;
                    end else begin
                        z_s   <= SIGNED_IN & a[31];
                        // Negating 0x80000000 wraps back to itself, which is the correct magnitude.
                        m     <= (SIGNED_IN && a[31]) ? -a : a;
                        z_e   <= 8'd31;
                        state <= st_convert_1;
                    end
                end
                st_convert_1: begin
                    if (!m[31]) begin
                        m   <= m << 1;
                        z_e <= z_e - 8'd1;
                    end else begin
                        state <= st_convert_2;
                    end
                end
                st_convert_2: begin
                    z_m       <= m[31:8];
                    guard     <= m[7];
                    round_bit <= m[6];
                    sticky    <= |m[5:0];
                    state     <= st_round;
                end
                st_round: begin
                    if (guard && (round_bit | sticky | z_m[0])) begin
                        // Carry-out wraps z_m to zero, which is exactly the fraction of the next power of two.
                        z_m <= z_m + 24'd1;
                        if (z_m == 24'hff_ffff) begin
                            z_e <= z_e + 8'd1;
                        end
                    end
                    state <= st_pack;
                end
                st_pack: begin
                    z     <= {z_s, z_e + 8'd127, z_m[22:0]};
                    state <= st_put_z;
                end
                st_put_z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= z;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= st_get_a;
                    end
                end
                default: begin
                    state <= st_get_a;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float: a signed and an unsigned instance, checked against an
// integer round-to-nearest-even model for result values, ordering and latency.
module tb_int_to_float;

    logic        clk;
    logic        rst;
    logic [31:0] a0, a1, z0, z1;
    logic        as0, as1, ak0, ak1, zs0, zs1, zk0, zk1;

    int passed = 0;
    int total  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] prev_z[2];
    bit          prev_v[2];

    int_to_float #(.SIGNED_IN(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .input_a(a0), .input_a_stb(as0), .input_a_ack(ak0),
        .output_z(z0), .output_z_stb(zs0), .output_z_ack(zk0)
    );

    int_to_float #(.SIGNED_IN(1'b0)) dut_u (
        .clk(clk), .rst(rst),
        .input_a(a1), .input_a_stb(as1), .input_a_ack(ak1),
        .output_z(z1), .output_z_stb(zs1), .output_z_ack(zk1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Magnitude of the operand as the spec defines it, widened so nothing wraps.
    function automatic logic [63:0] magnitude(logic [31:0] a, bit sg);
        if (sg && a[31]) return 64'h1_0000_0000 - {32'd0, a};
        return {32'd0, a};
    endfunction

    function automatic int lead_one(logic [63:0] mag);
        for (int i = 63; i >= 0; i--) if (mag[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model(logic [31:0] a, bit sg);
        logic [63:0] mag, mant, rem, half;
        int e, sh;
        bit s;
        s   = sg && a[31];
        mag = magnitude(a, sg);
        if (mag == 64'd0) return 32'h0;
        e = lead_one(mag);
        if (e <= 23) begin
            mant = mag << (23 - e);
        end else begin
            sh   = e - 23;
            mant = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                e++;
            end
        end
        return {s, 8'(e + 127), mant[22:0]};
    endfunction

    function automatic int exp_lat(logic [31:0] a, bit sg);
        int p;
        p = lead_one(magnitude(a, sg));
        if (p < 0) return 2;
        return 6 + (31 - p);
    endfunction

    task automatic drive_a(int w, logic [31:0] v, logic s);
        if (w == 0) begin a0 = v; as0 = s; end
        else begin a1 = v; as1 = s; end
    endtask

    task automatic drive_zack(int w, logic v);
        if (w == 0) zk0 = v;
        else zk1 = v;
    endtask

    function automatic logic aack(int w);
        return (w == 0) ? ak0 : ak1;
    endfunction

    function automatic logic zstb(int w);
        return (w == 0) ? zs0 : zs1;
    endfunction

    function automatic logic [31:0] zval(int w);
        return (w == 0) ? z0 : z1;
    endfunction

    // Scoreboard: every accepted operand queues its expected result, every accepted result pops one.
    task automatic mon(int w);
        logic [31:0] ex;
        logic        ia, is, os, ok;
        logic [31:0] ov, iv;
        ia = aack(w); os = zstb(w); ov = zval(w);
        is = (w == 0) ? as0 : as1;
        iv = (w == 0) ? a0 : a1;
        ok = (w == 0) ? zk0 : zk1;
        if (rst) begin
            if (w == 0) q0.delete(); else q1.delete();
            prev_v[w] = 1'b0;
            return;
        end
        if (ia && is) begin
            if (w == 0) q0.push_back(model(iv, 1'b1));
            else q1.push_back(model(iv, 1'b0));
        end
        if (os) begin
            chk($sformatf("in_ack_low_in_put_z[%0d]", w), {31'd0, ia}, 32'd0);
            if (prev_v[w]) chk($sformatf("z_stable[%0d]", w), ov, prev_z[w]);
            if (ok) begin
                if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                    chk($sformatf("spurious_output[%0d]", w), 32'd1, 32'd0);
                end else begin
                    ex = (w == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("z_value[%0d]", w), ov, ex);
                end
            end
        end
        prev_v[w] = os && !ok;
        prev_z[w] = ov;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // One full transaction; called and returns at posedge+1.
    task automatic xfer(int w, logic [31:0] a, int gap, int hold, bit poke, output logic [31:0] zr);
        bit sg, cap;
        int n, lat;
        sg = (w == 0);
        zr = 32'hx;
        repeat (gap) begin @(posedge clk); #1; end
        drive_a(w, a, 1'b1);
        cap = 1'b0;
        n = 0;
        while (!cap && n < 200) begin
            cap = aack(w);
            @(posedge clk); #1;
            n++;
        end
        drive_a(w, $urandom, 1'b0);
        if (!cap) begin
            chk("capture_timeout", 32'd1, 32'd0);
            return;
        end
        lat = 0;
        while (!zstb(w) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency a=%h", a), 32'(lat), 32'(exp_lat(a, sg)));
        if (!zstb(w)) return;
        zr = zval(w);
        repeat (hold) begin
            if (poke) drive_a(w, 32'hDEAD_BEEF, 1'b1);
            @(posedge clk); #1;
        end
        drive_a(w, 32'd0, 1'b0);
        drive_zack(w, 1'b1);
        @(posedge clk); #1;
        drive_zack(w, 1'b0);
        chk("stb_fall", {31'd0, zstb(w)}, 32'd0);
        chk("in_ack_after_accept", {31'd0, aack(w)}, 32'd0);
        @(posedge clk); #1;
        chk("in_ack_rise", {31'd0, aack(w)}, 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(0, 31);
            2: v = -($urandom >> $urandom_range(0, 31));
            3: v = ($urandom_range(1, 255) << 24) | ($urandom_range(0, 1) << 7) | $urandom_range(0, 1);
            default: begin
                case ($urandom_range(0, 6))
                    0: v = 32'h0;
                    1: v = 32'h1;
                    2: v = 32'hFFFF_FFFF;
                    3: v = 32'h8000_0000;
                    4: v = 32'h7FFF_FFFF;
                    5: v = 32'h0100_0001;
                    default: v = 32'h0100_0003;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic random_run(int w, int n);
        logic [31:0] zr;
        for (int i = 0; i < n; i++) begin
            xfer(w, rand_operand(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), zr);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] zr;
        rst = 1'b1;
        a0 = '0; a1 = '0; as0 = 1'b0; as1 = 1'b0; zk0 = 1'b0; zk1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ack_s", {31'd0, ak0}, 32'd0);
        chk("reset_out_stb_s", {31'd0, zs0}, 32'd0);
        chk("reset_in_ack_u", {31'd0, ak1}, 32'd0);
        chk("reset_out_stb_u", {31'd0, zs1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ack_s", {31'd0, ak0}, 32'd1);
        chk("post_reset_ack_u", {31'd0, ak1}, 32'd1);

        chk("model_1", model(32'd1, 1'b1), 32'h3F80_0000);
        chk("model_m1", model(32'hFFFF_FFFF, 1'b1), 32'hBF80_0000);
        chk("model_tie_even", model(32'd16777217, 1'b1), 32'h4B80_0000);
        chk("model_tie_odd", model(32'd16777219, 1'b1), 32'h4B80_0002);
        chk("model_min", model(32'h8000_0000, 1'b1), 32'hCF00_0000);
        chk("model_max_carry", model(32'h7FFF_FFFF, 1'b1), 32'h4F00_0000);
        chk("model_u_max", model(32'hFFFF_FFFF, 1'b0), 32'h4F80_0000);

        xfer(0, 32'd1, 0, 0, 1'b0, zr);          chk("t1_one", zr, 32'h3F80_0000);
        xfer(0, 32'hFFFF_FFFF, 1, 0, 1'b0, zr);  chk("t1_minus_one", zr, 32'hBF80_0000);
        xfer(0, 32'd0, 0, 0, 1'b0, zr);          chk("t2_zero", zr, 32'h0000_0000);
        xfer(0, 32'd16777217, 0, 1, 1'b0, zr);   chk("t2_tie_even", zr, 32'h4B80_0000);
        xfer(0, 32'd16777219, 0, 0, 1'b0, zr);   chk("t2_tie_odd", zr, 32'h4B80_0002);
        xfer(0, 32'h8000_0000, 0, 0, 1'b0, zr);  chk("t3_int_min", zr, 32'hCF00_0000);
        xfer(0, 32'h7FFF_FFFF, 0, 0, 1'b0, zr);  chk("t3_carry_out", zr, 32'h4F00_0000);
        xfer(1, 32'hFFFF_FFFF, 0, 0, 1'b0, zr);  chk("t3_unsigned_max", zr, 32'h4F80_0000);
        xfer(1, 32'h8000_0000, 0, 0, 1'b0, zr);  chk("t3_unsigned_msb", zr, 32'h4F00_0000);
        xfer(0, 32'd1000, 0, 10, 1'b1, zr);      chk("t4_backpressure", zr, 32'h447A_0000);

        // Abort a conversion in flight; its result must never appear.
        drive_a(0, 32'd1, 1'b1);
        @(posedge clk); #1;
        drive_a(0, 32'd0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_stb_after_reset", {31'd0, zs0}, 32'd0);
        chk("t5_ack_after_reset", {31'd0, ak0}, 32'd0);
        @(posedge clk); #1;
        chk("t5_ack_rise", {31'd0, ak0}, 32'd1);
        xfer(0, 32'd3, 0, 0, 1'b0, zr);          chk("t5_three", zr, 32'h4040_0000);

        fork
            random_run(0, 3000);
            random_run(1, 3000);
        join

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_empty_s", 32'(q0.size()), 32'd0);
        chk("queue_empty_u", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
